// File: rtl/nolinear_seq_if.sv
// ============================================================================
// Module   : nolinear_seq_if
// Brief    : Request handshake (valid/ready, opcode, packed operands) into
//            the nolinear sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nolinear_seq_if #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DATA_NUM        = 4
);
    logic                                start_valid;
    logic                                start_ready;
    logic [1:0]                          op;
    logic [DATA_NUM*FIX_POINT_WIDTH-1:0] op_data;

    modport master (output start_valid, output op, output op_data, input  start_ready);
    modport slave  (input  start_valid, input  op, input  op_data, output start_ready);
endinterface

`default_nettype wire

// File: rtl/nolinear_seq.sv
// ============================================================================
// Module   : nolinear_seq
// Brief    : Two-round timed sequencer driving the nolinear datapath controls.
//            Optional macro NOLINEAR_SEQ_OPCNT_EN adds a 16-bit done counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nolinear_seq #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DATA_NUM        = 4,
    parameter int R1_CYCLES       = 50,
    parameter int R2_CYCLES       = 1,
    parameter int CNT_W           = 8
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    nolinear_seq_if.slave                            req,
    output logic [1:0]                               mode,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0]      in,
    output logic [2:0]                               s_in,
    output logic                                     s_mux,
    output logic [2:0]                               s_mult,
    output logic                                     s_add,
    output logic                                     en_mult,
    output logic                                     en_add,
    output logic                                     valid,
    output logic                                     done,
`ifdef NOLINEAR_SEQ_OPCNT_EN
    output logic [15:0]                              op_cnt,
`endif
    output logic                                     err
);

    localparam int              c_dw         = DATA_NUM * FIX_POINT_WIDTH;
    localparam logic [CNT_W-1:0] c_r1_last   = CNT_W'(R1_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_r2_last   = CNT_W'(R2_CYCLES - 1);
    localparam logic [1:0]      c_op_illegal = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_R1   = 2'd1,
        S_R2   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [c_dw-1:0]  r_in, w_in_nxt;
    logic [10:0]      r_ctrl, w_ctrl_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
`ifdef NOLINEAR_SEQ_OPCNT_EN
    logic [15:0]      r_op_cnt;
`endif

    // Control word layout: {s_in, s_mux, s_mult, s_add, en_mult, en_add, valid}
    function automatic logic [10:0] f_ctrl(input logic [1:0] op_sel, input logic round2);
        logic [10:0] v;
        v = '0;
        case (op_sel)
            2'b00:   v = round2 ? {3'd1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1}
                                : {3'd0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
            2'b01:   v = round2 ? {3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1}
                                : {3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
            2'b10:   v = {3'd2, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, round2};
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_in_nxt    = r_in;
        w_ctrl_nxt  = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req.start_valid) begin
                    if (req.op == c_op_illegal) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_R1;
                        w_cnt_nxt   = '0;
                        w_mode_nxt  = req.op;
                        w_in_nxt    = req.op_data;
                        w_ctrl_nxt  = f_ctrl(req.op, 1'b0);
                    end
                end
            end
            S_R1: begin
                if (r_cnt == c_r1_last) begin
                    w_state_nxt = S_R2;
                    w_cnt_nxt   = '0;
                    w_ctrl_nxt  = f_ctrl(r_mode, 1'b1);
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_ctrl_nxt  = f_ctrl(r_mode, 1'b0);
                end
            end
            S_R2: begin
                if (r_cnt == c_r2_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_ctrl_nxt  = f_ctrl(r_mode, 1'b1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= '0;
            r_in    <= '0;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_in    <= w_in_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef NOLINEAR_SEQ_OPCNT_EN
    // Counts completed operations only; rejected opcodes never reach done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_cnt <= '0;
        end else if (w_done_nxt) begin
            r_op_cnt <= r_op_cnt + 16'd1;
        end
    end
    assign op_cnt = r_op_cnt;
`endif

    assign req.start_ready = (r_state == S_IDLE);
    assign mode            = r_mode;
    assign in              = r_in;
    assign {s_in, s_mux, s_mult, s_add, en_mult, en_add, valid} = r_ctrl;
    assign done            = r_done;
    assign err             = r_err;

endmodule

`default_nettype wire
